ll_detect_unit: RTL
===================

# ll_detect_unit

Consumer of the line-length feature stream produced by `ll_comp_unit`. Each valid line-length sample is compared against a slowly adapting background baseline; the block reports seizure onset/offset events with onset debounce and offset hold. It sits directly downstream of `ll_comp_unit` and shares its clock, reset and `en` sample strobe.

## Interface
- `input_width`, 31: MSB index of `din` (sample is `input_width+1` bits, signed), same convention as `ll_comp_unit`.
- `ALPHA_SHIFT`, 4: baseline EMA shift, baseline += (x − baseline) >>> ALPHA_SHIFT.
- `THR_SHIFT`, 1: threshold = baseline << THR_SHIFT.
- `WARMUP`, 16: samples to settle the baseline before detection is enabled (≥1).
- `ONSET_CNT`, 4: consecutive exceeding samples required to declare onset (≥1).
- `HOLD_CNT`, 16: consecutive non-exceeding samples required to declare offset (≥1).

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  sample-valid strobe; `din` is consumed only on edges where `en`=1.
- `din`  in  input_width+1  signed line-length sample (`ll_comp_unit` dout).
- `detect`  out  1  high while in DETECT.
- `onset`  out  1  one-cycle pulse on entry to DETECT.
- `offset`  out  1  one-cycle pulse on exit from DETECT.
- `baseline`  out  input_width+1  current baseline (unsigned value, MSB always 0).
- `state`  out  2  WARMUP=0, IDLE=1, ARMING=2, DETECT=3.
- `event_count`  out  16  number of onsets since reset, saturates at 0xFFFF.

## Operation
- Input conditioning: x = 0 if `din` < 0, else `din`.
- Exceed: x > (baseline << THR_SHIFT), strict, compared at width input_width+1+THR_SHIFT (no overflow, no saturation).
- EMA: computed at input_width+2 signed, arithmetic shift (floor); result stored in `baseline`.
- WARMUP: first sample after reset loads baseline = x; each later sample applies EMA. Warmup counter increments per sample; on the WARMUP-th sample → IDLE. No exceed checks in WARMUP.
- IDLE: non-exceeding sample → EMA update, stay. Exceeding sample → onset counter = 1; if ONSET_CNT = 1 → DETECT directly, else → ARMING. Baseline not updated on exceeding samples.
- ARMING: exceeding sample → counter+1; on reaching ONSET_CNT → DETECT. Non-exceeding sample → IDLE, counter cleared, EMA update with that sample.
- DETECT: baseline frozen. Entry loads hold counter = HOLD_CNT. Exceeding sample reloads HOLD_CNT. Non-exceeding sample decrements; when it reaches 0 → IDLE, `offset` pulse.
- `event_count` increments on every DETECT entry; holds at 0xFFFF.
- `en`=0 edges: no state, counter or baseline change; pulses low.

## Timing
- Reset (async, immediate): state=WARMUP, all counters 0, baseline=0, `detect`/`onset`/`offset`=0, `event_count`=0.
- All outputs registered; latency 1 clock: effect of the sample on edge N is visible after edge N.
- `onset`/`offset` high exactly one cycle, regardless of `en` on the following cycle.
- `detect` rises in the same cycle as `onset`, falls in the same cycle as `offset`.
- Back-to-back `en` every cycle fully supported; no backpressure.
- Reset asserted mid-ARMING/DETECT: aborts with no `offset` pulse; restarts in WARMUP.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs 0 and `state`=0 before the next edge; release, no change until first `en`.
- Warmup: 16 samples of 100 with `en`=1 every cycle → `baseline`=100, `state`=1 after the 16th edge, `detect`=0 throughout.
- Onset: baseline 100, feed four samples of 201 → `state`=2 after the 1st, `onset`=1 for one cycle and `detect`=1 after the 4th, `event_count`=1; four samples of 200 → no exceedance, stays IDLE.
- Abort: baseline 100, feed 201, 201, 201, 150 → returns to IDLE, no onset, `baseline`=103.
- Hold: in DETECT, feed 9×100, 1×300, then 16×100 → `detect` stays high through the first 10 samples; `offset` pulses after the 16th trailing sample; gaps with `en`=0 inserted change nothing.
- Clamp/reset mid-event: baseline 100 in IDLE, `din`=−5 → `baseline`=93; then drive to DETECT and assert `rst` → `detect`=0, `event_count`=0, no `offset` pulse.

Source files
------------

// File: rtl/ll_detect_unit.sv
// rtl/ll_detect_unit.sv - line-length seizure detector with adaptive baseline
// Onset is debounced over consecutive exceedances; offset needs a run of quiet samples.
module ll_detect_unit #(
  parameter int input_width = 31,
  parameter int ALPHA_SHIFT = 4,
  parameter int THR_SHIFT   = 1,
  parameter int WARMUP      = 16,
  parameter int ONSET_CNT   = 4,
  parameter int HOLD_CNT    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [input_width:0]   din,
  output logic                   detect,
  output logic                   onset,
  output logic                   offset,
  output logic [input_width:0]   baseline,
  output logic [1:0]             state,
  output logic [15:0]            event_count
);

  localparam int W   = input_width + 1;
  localparam int CW  = W + THR_SHIFT;
  localparam int WCW = $clog2(WARMUP + 1);
  localparam int OCW = $clog2(ONSET_CNT + 1);
  localparam int HCW = $clog2(HOLD_CNT + 1);

  localparam logic [1:0] S_WARMUP = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ARMING = 2'd2;
  localparam logic [1:0] S_DETECT = 2'd3;

  localparam logic [WCW-1:0] WARMUP_L = WCW'(WARMUP);
  localparam logic [OCW-1:0] ONSET_L  = OCW'(ONSET_CNT);
  localparam logic [HCW-1:0] HOLD_L   = HCW'(HOLD_CNT);

  logic [WCW-1:0] warm_cnt, warm_cnt_n;
  logic [OCW-1:0] arm_cnt, arm_cnt_n;
  logic [HCW-1:0] hold_cnt, hold_cnt_n;
  logic [1:0]     state_n;
  logic [W-1:0]   base_n;
  logic [15:0]    event_n;
  logic           onset_n, offset_n;

  // Negative samples carry no energy, so they are clamped to zero.
  logic [W-1:0] x;
  assign x = din[input_width] ? '0 : din;

  logic [CW-1:0] thr, x_wide;
  logic          exceed;
  assign thr    = CW'(baseline) << THR_SHIFT;
  assign x_wide = CW'(x);
  assign exceed = x_wide > thr;

  // One extra bit keeps the difference signed; >>> floors toward -inf.
  logic signed [W:0] diff, step, ema_sum;
  logic [W-1:0]      ema;
  assign diff    = $signed({1'b0, x}) - $signed({1'b0, baseline});
  assign step    = diff >>> ALPHA_SHIFT;
  assign ema_sum = $signed({1'b0, baseline}) + step;
  assign ema     = ema_sum[W-1:0];

  always_comb begin
    state_n    = state;
    base_n     = baseline;
    warm_cnt_n = warm_cnt;
    arm_cnt_n  = arm_cnt;
    hold_cnt_n = hold_cnt;
    event_n    = event_count;
    onset_n    = 1'b0;
    offset_n   = 1'b0;
    if (en) begin
      case (state)
        S_WARMUP: begin
          base_n     = (warm_cnt == '0) ? x : ema;
          warm_cnt_n = warm_cnt + WCW'(1);
          if (warm_cnt_n == WARMUP_L) state_n = S_IDLE;
        end
        S_IDLE, S_ARMING: begin
          if (exceed) begin
            arm_cnt_n = (state == S_IDLE) ? OCW'(1) : arm_cnt + OCW'(1);
            if (arm_cnt_n == ONSET_L) begin
              state_n    = S_DETECT;
              hold_cnt_n = HOLD_L;
              arm_cnt_n  = '0;
              onset_n    = 1'b1;
              if (event_count != 16'hFFFF) event_n = event_count + 16'd1;
            end else begin
              state_n = S_ARMING;
            end
          end else begin
            state_n   = S_IDLE;
            arm_cnt_n = '0;
            base_n    = ema;
          end
        end
        default: begin
          // Baseline stays frozen for the whole event.
          if (exceed) begin
            hold_cnt_n = HOLD_L;
          end else begin
            hold_cnt_n = hold_cnt - HCW'(1);
            if (hold_cnt_n == '0) begin
              state_n  = S_IDLE;
              offset_n = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_WARMUP;
      baseline    <= '0;
      warm_cnt    <= '0;
      arm_cnt     <= '0;
      hold_cnt    <= '0;
      event_count <= '0;
      onset       <= 1'b0;
      offset      <= 1'b0;
      detect      <= 1'b0;
    end else begin
      state       <= state_n;
      baseline    <= base_n;
      warm_cnt    <= warm_cnt_n;
      arm_cnt     <= arm_cnt_n;
      hold_cnt    <= hold_cnt_n;
      event_count <= event_n;
      onset       <= onset_n;
      offset      <= offset_n;
      detect      <= (state_n == S_DETECT);
    end
  end

endmodule
